// File: rtl/host_direct_arbiter.sv
// Round-robin share of the host-direct command port with per-requester credits and tag remapping.
// Define HOST_DIRECT_ARB_STATS_EN to add grant/stall counters (stat_grant_cnt_o, stat_stall_cnt_o).
module host_direct_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int CMD_W           = 584,
    parameter int ID_W            = 8,
    parameter int NUM_TAGS        = 16,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*CMD_W-1:0] req_cmd_i,
    input  logic [NUM_REQ*ID_W-1:0] req_id_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic [NUM_REQ*ID_W-1:0] resp_id_o,
    output logic                    hd_req_valid_o,
    input  logic                    hd_req_ready_i,
    output logic [CMD_W-1:0]        hd_req_cmd_o,
    output logic [ID_W-1:0]         hd_req_id_o,
    input  logic                    hd_resp_valid_i,
    input  logic [ID_W-1:0]         hd_resp_id_i,
    output logic                    err_o
`ifdef HOST_DIRECT_ARB_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]   stat_grant_cnt_o,
    output logic [31:0]             stat_stall_cnt_o
`endif
);
    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int REQ_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    // Handshakes: a transfer happens on a clock edge where valid && ready are both high;
    // valid never waits on ready, and a held valid keeps its payload stable until accepted.
    logic [NUM_TAGS-1:0] tag_busy_q;
    logic [REQ_W-1:0]    tag_src_q [NUM_TAGS];
    logic [ID_W-1:0]     tag_id_q  [NUM_TAGS];
    logic [CNT_W-1:0]    credit_q  [NUM_REQ];
    logic [ID_W-1:0]     resp_id_q [NUM_REQ];
    logic [REQ_W-1:0]    rr_ptr_q;

    logic                loadable;
    logic                grant;
    logic                comp_hit;
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  credit_inc;
    logic [NUM_REQ-1:0]  credit_dec;
    logic [REQ_W-1:0]    winner;
    logic [REQ_W-1:0]    scan_idx;
    logic [REQ_W-1:0]    comp_src;
    logic [TAG_W-1:0]    free_tag;
    logic [TAG_W-1:0]    comp_tag;
    logic [CMD_W-1:0]    win_cmd;
    logic [ID_W-1:0]     win_id;
    int                  scan;

    always_comb begin
        loadable = !hd_req_valid_o || hd_req_ready_i;
        for (int r = 0; r < NUM_REQ; r++)
            eligible[r] = req_valid_i[r] && (credit_q[r] < CNT_W'(MAX_OUTSTANDING));

        // Allocation sees only the registered bitmap, so a tag freed this cycle waits one cycle.
        free_tag = '0;
        for (int t = NUM_TAGS - 1; t >= 0; t--)
            if (!tag_busy_q[t]) free_tag = TAG_W'(t);

        // Scan from the far end so the requester closest to the pointer is written last.
        winner   = '0;
        scan     = 0;
        scan_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan = int'(rr_ptr_q) + i;
            if (scan >= NUM_REQ) scan = scan - NUM_REQ;
            scan_idx = REQ_W'(scan);
            if (eligible[scan_idx]) winner = scan_idx;
        end

        grant = !rst_i && loadable && !(&tag_busy_q) && (|eligible);

        win_cmd = '0;
        win_id  = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready_o[r] = grant && (winner == REQ_W'(r));
            if (winner == REQ_W'(r)) begin
                win_cmd = req_cmd_i[r*CMD_W +: CMD_W];
                win_id  = req_id_i[r*ID_W +: ID_W];
            end
        end

        comp_tag = hd_resp_id_i[TAG_W-1:0];
        comp_hit = hd_resp_valid_i && tag_busy_q[comp_tag];
        comp_src = tag_src_q[comp_tag];

        for (int r = 0; r < NUM_REQ; r++) begin
            credit_inc[r] = grant && (winner == REQ_W'(r));
            credit_dec[r] = comp_hit && (comp_src == REQ_W'(r));
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_busy_q     <= '0;
            rr_ptr_q       <= '0;
            hd_req_valid_o <= 1'b0;
            hd_req_cmd_o   <= '0;
            hd_req_id_o    <= '0;
            resp_valid_o   <= '0;
            err_o          <= 1'b0;
            for (int r = 0; r < NUM_REQ; r++) begin
                credit_q[r]  <= '0;
                resp_id_q[r] <= '0;
            end
        end else begin
            resp_valid_o <= '0;
            if (comp_hit) begin
                tag_busy_q[comp_tag]   <= 1'b0;
                resp_valid_o[comp_src] <= 1'b1;
                resp_id_q[comp_src]    <= tag_id_q[comp_tag];
            end else if (hd_resp_valid_i) begin
                err_o <= 1'b1;
            end

            if (grant) begin
                tag_busy_q[free_tag] <= 1'b1;
                rr_ptr_q <= (winner == REQ_W'(NUM_REQ - 1)) ? '0 : winner + REQ_W'(1);
            end

            if (loadable) begin
                hd_req_valid_o <= grant;
                if (grant) begin
                    hd_req_cmd_o <= win_cmd;
                    hd_req_id_o  <= ID_W'(free_tag);
                end
            end

            for (int r = 0; r < NUM_REQ; r++) begin
                if (credit_inc[r] && !credit_dec[r])
                    credit_q[r] <= credit_q[r] + CNT_W'(1);
                else if (credit_dec[r] && !credit_inc[r])
                    credit_q[r] <= credit_q[r] - CNT_W'(1);
            end
        end
    end

    // Tag table contents are only meaningful while the busy bit is set, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (grant) begin
            tag_src_q[free_tag] <= winner;
            tag_id_q[free_tag]  <= win_id;
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_resp_id
        assign resp_id_o[r*ID_W +: ID_W] = resp_id_q[r];
    end

    if (ID_W > TAG_W) begin : g_unused_id
        logic unused_resp_id_bits;
        assign unused_resp_id_bits = ^hd_resp_id_i[ID_W-1:TAG_W];
    end

`ifdef HOST_DIRECT_ARB_STATS_EN
    logic [31:0] grant_cnt_q [NUM_REQ];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_stall_cnt_o <= '0;
            for (int r = 0; r < NUM_REQ; r++) grant_cnt_q[r] <= '0;
        end else begin
            if (grant) grant_cnt_q[winner] <= grant_cnt_q[winner] + 32'd1;
            if (hd_req_valid_o && !hd_req_ready_i) stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_stat
        assign stat_grant_cnt_o[r*32 +: 32] = grant_cnt_q[r];
    end
`endif

endmodule

// File: tb/tb_host_direct_arbiter.sv
// Self-checking bench for host_direct_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of tags, credits and round-robin order.
module tb_host_direct_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int CMD_W    = 584;
    localparam int ID_W     = 8;
    localparam int NUM_TAGS = 16;
    localparam int MAX_OUT  = 4;

    logic                     clk;
    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*CMD_W-1:0] req_cmd;
    logic [NUM_REQ*ID_W-1:0]  req_id;
    logic [NUM_REQ-1:0]       resp_valid;
    logic [NUM_REQ*ID_W-1:0]  resp_id;
    logic                     hd_valid;
    logic                     hd_ready;
    logic [CMD_W-1:0]         hd_cmd;
    logic [ID_W-1:0]          hd_id;
    logic                     hd_resp_valid;
    logic [ID_W-1:0]          hd_resp_id;
    logic                     err;
`ifdef HOST_DIRECT_ARB_STATS_EN
    logic [NUM_REQ*32-1:0]    stat_grant;
    logic [31:0]              stat_stall;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: one entry per in-flight tag.
    int               q_tag[$];
    int               q_src[$];
    logic [ID_W-1:0]  exp_q[$];

    host_direct_arbiter #(
        .NUM_REQ(NUM_REQ), .CMD_W(CMD_W), .ID_W(ID_W),
        .NUM_TAGS(NUM_TAGS), .MAX_OUTSTANDING(MAX_OUT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_cmd_i(req_cmd), .req_id_i(req_id),
        .resp_valid_o(resp_valid), .resp_id_o(resp_id),
        .hd_req_valid_o(hd_valid), .hd_req_ready_i(hd_ready),
        .hd_req_cmd_o(hd_cmd), .hd_req_id_o(hd_id),
        .hd_resp_valid_i(hd_resp_valid), .hd_resp_id_i(hd_resp_id),
        .err_o(err)
`ifdef HOST_DIRECT_ARB_STATS_EN
        , .stat_grant_cnt_o(stat_grant), .stat_stall_cnt_o(stat_stall)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "simulation time limit reached");
    end

    function automatic logic [CMD_W-1:0] rand_cmd();
        logic [CMD_W-1:0] v;
        v = '0;
        for (int i = 0; i < (CMD_W + 31) / 32; i++) v = {v[CMD_W-33:0], $urandom};
        return v;
    endfunction

    function automatic int find_tag(int t);
        foreach (q_tag[i]) if (q_tag[i] == t) return i;
        return -1;
    endfunction

    function automatic int credit_of(int r);
        int n = 0;
        foreach (q_src[i]) if (q_src[i] == r) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req_valid = '0;
        hd_ready = 1'b0;
        hd_resp_valid = 1'b0;
        hd_resp_id = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '1;
        req_cmd = '0;
        req_id = '0;
        hd_ready = 1'b1;
        hd_resp_valid = 1'b0;
        hd_resp_id = '0;
        tick();
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (hd_valid !== 1'b0) begin failures++; $display("FAIL reset_hd_valid got=%b exp=0", hd_valid); end
        checks++; if (hd_id !== 8'h00) begin failures++; $display("FAIL reset_hd_id got=%h exp=00", hd_id); end
        checks++; if (hd_cmd !== '0) begin failures++; $display("FAIL reset_hd_cmd got=%h exp=0", hd_cmd); end
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid); end
        checks++; if (resp_id !== 32'h0) begin failures++; $display("FAIL reset_resp_id got=%h exp=0", resp_id); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        rst = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_single();
        logic [CMD_W-1:0] c;
        apply_reset();
        c = rand_cmd();
        req_cmd[2*CMD_W +: CMD_W] = c;
        req_id[2*ID_W +: ID_W] = 8'h5A;
        req_valid = 4'b0100;
        hd_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready got=%b exp=0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (hd_valid !== 1'b1) begin failures++; $display("FAIL single_hd_valid got=%b exp=1", hd_valid); end
        checks++; if (hd_id !== 8'h00) begin failures++; $display("FAIL single_hd_id got=%h exp=00", hd_id); end
        checks++; if (hd_cmd !== c) begin failures++; $display("FAIL single_hd_cmd got=%h exp=%h", hd_cmd, c); end
        hd_resp_valid = 1'b1;
        hd_resp_id = 8'h00;
        tick();
        hd_resp_valid = 1'b0;
        checks++; if (resp_valid !== 4'b0100) begin failures++; $display("FAIL single_resp_valid got=%b exp=0100", resp_valid); end
        checks++; if (resp_id[2*ID_W +: ID_W] !== 8'h5A) begin failures++; $display("FAIL single_resp_id got=%h exp=5a", resp_id[2*ID_W +: ID_W]); end
        checks++; if (hd_valid !== 1'b0) begin failures++; $display("FAIL single_hd_drain got=%b exp=0", hd_valid); end
        tick();
        checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL single_resp_pulse got=%b exp=0000", resp_valid); end
        checks++; if (resp_id[2*ID_W +: ID_W] !== 8'h5A) begin failures++; $display("FAIL single_resp_hold got=%h exp=5a", resp_id[2*ID_W +: ID_W]); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err); end
    endtask

    task automatic test_fairness();
        logic [NUM_REQ-1:0] e;
        logic [ID_W-1:0] eid;
        apply_reset();
        for (int r = 0; r < NUM_REQ; r++) req_id[r*ID_W +: ID_W] = ID_W'(8'h10 + r);
        req_valid = '1;
        hd_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            #1;
            e = NUM_REQ'(1 << (k % NUM_REQ));
            checks++; if (req_ready !== e) begin failures++; $display("FAIL fair_ready k=%0d got=%b exp=%b", k, req_ready, e); end
            tick();
            eid = ID_W'(k % 2);
            checks++; if (hd_valid !== 1'b1 || hd_id !== eid) begin failures++; $display("FAIL fair_hd k=%0d got=%b/%h exp=1/%h", k, hd_valid, hd_id, eid); end
            if (k > 0) begin
                e = NUM_REQ'(1 << ((k - 1) % NUM_REQ));
                eid = ID_W'(8'h10 + (k - 1) % NUM_REQ);
                checks++; if (resp_valid !== e) begin failures++; $display("FAIL fair_resp k=%0d got=%b exp=%b", k, resp_valid, e); end
                checks++; if (resp_id[((k - 1) % NUM_REQ)*ID_W +: ID_W] !== eid) begin failures++; $display("FAIL fair_resp_id k=%0d got=%h exp=%h", k, resp_id[((k - 1) % NUM_REQ)*ID_W +: ID_W], eid); end
            end
            hd_resp_valid = 1'b1;
            hd_resp_id = ID_W'(k % 2);
        end
        req_valid = '0;
        tick();
        hd_resp_valid = 1'b0;
        tick();
    endtask

    task automatic test_credit_cap();
        apply_reset();
        req_id = '0;
        req_valid = 4'b0001;
        hd_ready = 1'b1;
        for (int k = 0; k < MAX_OUT; k++) begin
            #1;
            checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL credit_ready k=%0d got=%b exp=0001", k, req_ready); end
            tick();
            checks++; if (hd_id !== ID_W'(k)) begin failures++; $display("FAIL credit_tag k=%0d got=%h exp=%h", k, hd_id, ID_W'(k)); end
        end
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL credit_full got=%b exp=0000", req_ready); end
        tick();
        checks++; if (hd_valid !== 1'b0) begin failures++; $display("FAIL credit_idle got=%b exp=0", hd_valid); end
        req_valid = 4'b0011;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL credit_skip got=%b exp=0010", req_ready); end
        tick();
        checks++; if (hd_id !== 8'h04) begin failures++; $display("FAIL credit_skip_tag got=%h exp=04", hd_id); end
        req_valid = 4'b0001;
        hd_resp_valid = 1'b1;
        hd_resp_id = 8'h02;
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL credit_still_full got=%b exp=0000", req_ready); end
        tick();
        hd_resp_valid = 1'b0;
        checks++; if (resp_valid !== 4'b0001) begin failures++; $display("FAIL credit_resp got=%b exp=0001", resp_valid); end
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL credit_regrant got=%b exp=0001", req_ready); end
        tick();
        checks++; if (hd_valid !== 1'b1 || hd_id !== 8'h02) begin failures++; $display("FAIL credit_reuse got=%b/%h exp=1/02", hd_valid, hd_id); end
    endtask

    task automatic test_tag_exhaustion();
        logic [NUM_REQ-1:0] e;
        apply_reset();
        for (int r = 0; r < NUM_REQ; r++) req_id[r*ID_W +: ID_W] = ID_W'(8'h30 + r);
        req_valid = '1;
        hd_ready = 1'b1;
        for (int k = 0; k < NUM_TAGS; k++) begin
            #1;
            e = NUM_REQ'(1 << (k % NUM_REQ));
            checks++; if (req_ready !== e) begin failures++; $display("FAIL exh_ready k=%0d got=%b exp=%b", k, req_ready, e); end
            tick();
            checks++; if (hd_id !== ID_W'(k)) begin failures++; $display("FAIL exh_tag k=%0d got=%h exp=%h", k, hd_id, ID_W'(k)); end
        end
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL exh_none got=%b exp=0000", req_ready); end
        hd_resp_valid = 1'b1;
        hd_resp_id = 8'h07;
        tick();
        hd_resp_valid = 1'b0;
        checks++; if (resp_valid !== 4'b1000 || resp_id[3*ID_W +: ID_W] !== 8'h33) begin failures++; $display("FAIL exh_resp got=%b/%h exp=1000/33", resp_valid, resp_id[3*ID_W +: ID_W]); end
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL exh_regrant got=%b exp=1000", req_ready); end
        tick();
        checks++; if (hd_id !== 8'h07) begin failures++; $display("FAIL exh_reuse got=%h exp=07", hd_id); end
    endtask

    task automatic test_backpressure();
        logic [CMD_W-1:0] c0, c1;
        apply_reset();
        c0 = rand_cmd();
        c1 = rand_cmd();
        req_cmd[0 +: CMD_W] = c0;
        req_cmd[CMD_W +: CMD_W] = c1;
        req_valid = '1;
        hd_ready = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL bp_first got=%b exp=0001", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++; if (hd_valid !== 1'b1 || hd_id !== 8'h00 || hd_cmd !== c0) begin failures++; $display("FAIL bp_stable k=%0d got=%b/%h", k, hd_valid, hd_id); end
            #1;
            checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready k=%0d got=%b exp=0000", k, req_ready); end
            tick();
        end
`ifdef HOST_DIRECT_ARB_STATS_EN
        checks++; if (stat_stall !== 32'd5) begin failures++; $display("FAIL bp_stall_cnt got=%0d exp=5", stat_stall); end
        checks++; if (stat_grant[31:0] !== 32'd1) begin failures++; $display("FAIL bp_grant_cnt got=%0d exp=1", stat_grant[31:0]); end
`endif
        hd_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL bp_release got=%b exp=0010", req_ready); end
        tick();
        checks++; if (hd_id !== 8'h01 || hd_cmd !== c1) begin failures++; $display("FAIL bp_next got=%h exp=01", hd_id); end
    endtask

    task automatic test_error_reset();
        apply_reset();
        hd_resp_valid = 1'b1;
        hd_resp_id = 8'h09;
        tick();
        hd_resp_valid = 1'b0;
        checks++; if (err !== 1'b1 || resp_valid !== 4'b0000) begin failures++; $display("FAIL err_free_tag got=%b/%b exp=1/0000", err, resp_valid); end
        tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
        apply_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_cleared got=%b exp=0", err); end
        req_valid = 4'b0001;
        hd_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (hd_id !== 8'h02) begin failures++; $display("FAIL err_inflight got=%h exp=02", hd_id); end
        rst = 1'b1;
        #1;
        checks++; if (hd_valid !== 1'b0 || hd_id !== 8'h00 || hd_cmd !== '0) begin failures++; $display("FAIL err_rst_hd got=%b/%h", hd_valid, hd_id); end
        checks++; if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || resp_id !== 32'h0 || err !== 1'b0) begin failures++; $display("FAIL err_rst_out got=%b/%b/%h/%b", req_ready, resp_valid, resp_id, err); end
        req_valid = '0;
        tick();
        rst = 1'b0;
        for (int t = 0; t < 3; t++) begin
            hd_resp_valid = 1'b1;
            hd_resp_id = ID_W'(t);
            tick();
            checks++; if (resp_valid !== 4'b0000) begin failures++; $display("FAIL err_stale_resp t=%0d got=%b exp=0000", t, resp_valid); end
        end
        hd_resp_valid = 1'b0;
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_stale got=%b exp=1", err); end
    endtask

    task automatic test_random();
        int rr, win, free_tag, idx, stalls, t;
        int grants[NUM_REQ];
        bit loadable, m_hv, m_err;
        logic [ID_W-1:0] m_hid;
        logic [CMD_W-1:0] m_hcmd;
        logic [NUM_REQ-1:0] m_rv, e_ready;
        logic [NUM_REQ*ID_W-1:0] m_rid;
        apply_reset();
        q_tag.delete();
        q_src.delete();
        exp_q.delete();
        rr = 0; stalls = 0; m_hv = 0; m_err = 0; m_hid = '0; m_hcmd = '0; m_rv = '0; m_rid = '0;
        foreach (grants[r]) grants[r] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            req_valid = NUM_REQ'($urandom_range(0, 15));
            for (int r = 0; r < NUM_REQ; r++) begin
                req_id[r*ID_W +: ID_W] = ID_W'($urandom);
                req_cmd[r*CMD_W +: CMD_W] = rand_cmd();
            end
            hd_ready = ($urandom_range(0, 3) != 0);
            hd_resp_valid = 1'b0;
            hd_resp_id = '0;
            if (q_tag.size() > 0 && $urandom_range(0, 3) < ((cyc % 100 < 50) ? 1 : 3)) begin
                hd_resp_valid = 1'b1;
                hd_resp_id = ID_W'(q_tag[$urandom_range(0, q_tag.size() - 1)] + NUM_TAGS * $urandom_range(0, 15));
            end else if ($urandom_range(0, 29) == 0) begin
                hd_resp_valid = 1'b1;
                hd_resp_id = ID_W'($urandom_range(0, 255));
            end

            loadable = !m_hv || hd_ready;
            free_tag = -1;
            for (int k = NUM_TAGS - 1; k >= 0; k--) if (find_tag(k) < 0) free_tag = k;
            win = -1;
            if (loadable && free_tag >= 0)
                for (int i = 0; i < NUM_REQ && win < 0; i++)
                    if (req_valid[(rr + i) % NUM_REQ] && credit_of((rr + i) % NUM_REQ) < MAX_OUT) win = (rr + i) % NUM_REQ;
            e_ready = '0;
            if (win >= 0) e_ready[win] = 1'b1;
            #1;
            checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end

            if (m_hv && !hd_ready) stalls++;
            m_rv = '0;
            t = int'(hd_resp_id) % NUM_TAGS;
            idx = hd_resp_valid ? find_tag(t) : -1;
            if (idx >= 0) begin
                m_rv[q_src[idx]] = 1'b1;
                m_rid[q_src[idx]*ID_W +: ID_W] = exp_q[idx];
                q_tag.delete(idx);
                q_src.delete(idx);
                exp_q.delete(idx);
            end else if (hd_resp_valid) begin
                m_err = 1'b1;
            end
            if (win >= 0) begin
                q_tag.push_back(free_tag);
                q_src.push_back(win);
                exp_q.push_back(req_id[win*ID_W +: ID_W]);
                rr = (win + 1) % NUM_REQ;
                grants[win]++;
            end
            if (loadable) begin
                m_hv = (win >= 0);
                if (win >= 0) begin
                    m_hid = ID_W'(free_tag);
                    m_hcmd = req_cmd[win*CMD_W +: CMD_W];
                end
            end

            tick();
            checks++; if (hd_valid !== m_hv) begin failures++; $display("FAIL rand_hd_valid cyc=%0d got=%b exp=%b", cyc, hd_valid, m_hv); end
            if (m_hv) begin
                checks++; if (hd_id !== m_hid) begin failures++; $display("FAIL rand_hd_id cyc=%0d got=%h exp=%h", cyc, hd_id, m_hid); end
                checks++; if (hd_cmd !== m_hcmd) begin failures++; $display("FAIL rand_hd_cmd cyc=%0d got=%h exp=%h", cyc, hd_cmd, m_hcmd); end
            end
            checks++; if (resp_valid !== m_rv) begin failures++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, m_rv); end
            checks++; if (resp_id !== m_rid) begin failures++; $display("FAIL rand_resp_id cyc=%0d got=%h exp=%h", cyc, resp_id, m_rid); end
            checks++; if (err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b exp=%b", cyc, err, m_err); end
        end
`ifdef HOST_DIRECT_ARB_STATS_EN
        for (int r = 0; r < NUM_REQ; r++) begin
            checks++; if (stat_grant[r*32 +: 32] !== 32'(grants[r])) begin failures++; $display("FAIL rand_grant_cnt r=%0d got=%0d exp=%0d", r, stat_grant[r*32 +: 32], grants[r]); end
        end
        checks++; if (stat_stall !== 32'(stalls)) begin failures++; $display("FAIL rand_stall_cnt got=%0d exp=%0d", stat_stall, stalls); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_credit_cap();
        test_tag_exhaustion();
        test_backpressure();
        test_error_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
